bus_decoder: RTL and testbench
==============================

# bus_decoder

Parametrised data-bus interconnect between the CPU data port and NREGIONS slave regions (I/O, RAM, ROM, peripherals). It replaces the fixed two-way memory/I-O split with configurable base addresses and per-region read wait states. Read wait states are enforced by a small read state machine that stalls the CPU and flags returned data. Writes are steered combinationally; reads are tracked through a registered region select and wait-state counter.

## Interface

Parameters:
- NREGIONS, 4, number of slave regions (2..8)
- ADDRBITS, 16, data address width
- DATABITS, 16, data bus width; must be 16 while dwrite_en is 2 bits
- BASES, {16'hC000, 16'h4000, 16'h2000, 16'h0000}, packed NREGIONS×ADDRBITS; slice i is region i base; strictly ascending; region 0 base must be 0
- WAITS, {4'd2, 4'd1, 4'd0, 4'd0}, packed NREGIONS×4; slice i is region i read wait states (0..15)
- WPROT, 0, NREGIONS-bit write-protect mask; only used with BUSDEC_WPROT_EN

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- dread_req  input  1  CPU read request, sampled with dread_addr
- dread_addr  input  ADDRBITS  read address
- dread_data  output  DATABITS  read data, valid when dread_valid
- dread_valid  output  1  read data strobe
- stall  output  1  read in progress; CPU must hold dread_req/dread_addr
- dwrite_addr  input  ADDRBITS  write address
- dwrite_en  input  2  byte write enables
- r_dread_en  output  NREGIONS  one-hot read strobe to regions
- r_dread_data  input  NREGIONS×DATABITS  packed region read data
- r_dwrite_en  output  2×NREGIONS  per-region byte enables, slice i for region i
- wp_fault  output  1  sticky write-protect violation flag

## Operation

- Decode: the selected region is the highest i with addr >= BASES[i]. Every address maps to exactly one region.
- Writes: r_dwrite_en[i] = dwrite_en for the decoded region and 0 elsewhere. Writes are accepted in any state, including during stall, with no buffering.
- Read FSM states: IDLE, WAIT.
- IDLE, dread_req=1:
  - assert r_dread_en[sel] this cycle;
  - latch sel into rsel;
  - load cnt = WAITS[sel].
  - If cnt=0, stay in IDLE and set dread_valid next cycle. Otherwise go to WAIT.
- WAIT:
  - stall=1;
  - cnt decrements each cycle;
  - when cnt reaches 1, return to IDLE and set dread_valid next cycle;
  - dread_req is ignored and r_dread_en is 0.
- Data: when dread_valid=1, dread_data = r_dread_data slice rsel (combinational mux on registered rsel). Otherwise dread_data = 0.
- Back-to-back: in IDLE, a new dread_req in the same cycle dread_valid is high is accepted.
- A read and a write to the same or different regions in the same cycle are both forwarded.
- Reset (reset=0 at a clock edge), including mid-WAIT:
  - state IDLE, cnt=0, rsel=0;
  - dread_valid=0, stall=0, dread_data=0, wp_fault=0;
  - r_dread_en and r_dwrite_en are 0 while reset is low.

## Timing

- Read request in cycle N to region with W wait states:
  - stall high cycles N+1..N+W;
  - dread_valid high for exactly one cycle, N+1+W.
- W=0 gives single-cycle latency: data is in cycle N+1, with no stall.
- r_dread_en is asserted in cycle N only.
- r_dwrite_en is combinational, in the same cycle as dwrite_en.
- stall is registered; it never asserts for W=0 reads.

## Configuration

- Macro: BUSDEC_WPROT_EN.
- Defined:
  - writes to region i with WPROT[i]=1 force r_dwrite_en slice i to 0;
  - any non-zero dwrite_en to such a region sets wp_fault on the next edge;
  - wp_fault stays set until reset.
- Undefined: WPROT is ignored, all writes are forwarded, and wp_fault is tied 0.

## Test plan

- Reset with a read pending in WAIT (region 3, W=2, reset low at cycle N+1) -> at the next edge stall=0, dread_valid=0, dread_data=0; no dread_valid afterwards.
- Read 16'h1FFF (region 0, W=0) with r_dread_data slice 0 = 16'hA5A5 -> r_dread_en=4'b0001 in N; dread_valid=1 and dread_data=16'hA5A5 in N+1; stall never high.
- Read 16'hC000 (region 3, W=2) with slice 3 = 16'h1234 -> stall high N+1..N+2; dread_valid high only at N+3 with 16'h1234.
- Boundary writes: dwrite_addr=16'h3FFF, dwrite_en=2'b10 -> r_dwrite_en slice 1=2'b10, others 0. Then 16'h4000 -> slice 2=2'b10.
- Write to 16'h2000 with dwrite_en=2'b11 during a region-3 stall -> r_dwrite_en slice 1=2'b11 in the same cycle; the read still completes at N+3.
- With BUSDEC_WPROT_EN and WPROT=4'b1000: write 16'hC010 with 2'b01 -> r_dwrite_en all 0; wp_fault=1 from the next cycle and held. Without the macro, the same write gives slice 3=2'b01 and wp_fault=0.

Source files
------------

// File: rtl/bus_decoder_if.sv
//------------------------------------------------------------------------------
// Module      : bus_decoder_if
// Description : CPU data-port / slave-region bus bundle for bus_decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_decoder_if #(
    parameter int NREGIONS = 4,
    parameter int ADDRBITS = 16,
    parameter int DATABITS = 16
);
    logic                         dread_req;
    logic [ADDRBITS-1:0]          dread_addr;
    logic [DATABITS-1:0]          dread_data;
    logic                         dread_valid;
    logic                         stall;
    logic [ADDRBITS-1:0]          dwrite_addr;
    logic [1:0]                   dwrite_en;
    logic [NREGIONS-1:0]          r_dread_en;
    logic [NREGIONS*DATABITS-1:0] r_dread_data;
    logic [2*NREGIONS-1:0]        r_dwrite_en;
    logic                         wp_fault;

    // Decoder side
    modport slave (
        input  dread_req, dread_addr, dwrite_addr, dwrite_en, r_dread_data,
        output dread_data, dread_valid, stall, r_dread_en, r_dwrite_en, wp_fault
    );

    // CPU plus region side, as seen by whoever drives the decoder
    modport master (
        output dread_req, dread_addr, dwrite_addr, dwrite_en, r_dread_data,
        input  dread_data, dread_valid, stall, r_dread_en, r_dwrite_en, wp_fault
    );
endinterface

`default_nettype wire

// File: rtl/bus_decoder.sv
//------------------------------------------------------------------------------
// Module      : bus_decoder
// Description : Base-address decoder between CPU data port and NREGIONS slave
//               regions with per-region read wait states. Optional write
//               protection is enabled with the macro BUSDEC_WPROT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_decoder #(
    parameter int                          NREGIONS = 4,
    parameter int                          ADDRBITS = 16,
    parameter int                          DATABITS = 16,
    parameter logic [NREGIONS*ADDRBITS-1:0] BASES   = {16'hC000, 16'h4000, 16'h2000, 16'h0000},
    parameter logic [NREGIONS*4-1:0]        WAITS   = {4'd2, 4'd1, 4'd0, 4'd0},
    parameter logic [NREGIONS-1:0]          WPROT   = '0
) (
    input  wire logic clk,
    input  wire logic reset,
    bus_decoder_if.slave bus
);

    localparam int SELW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [SELW-1:0]     r_rsel;
    logic [SELW-1:0]     w_rsel_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic [NREGIONS-1:0] w_rd_en;
    logic [SELW-1:0]     w_rd_sel;
    logic [SELW-1:0]     w_wr_sel;
    logic [3:0]          w_rd_wait;
    logic [2*NREGIONS-1:0] w_wr_en;

    // Bases are strictly ascending, so the last match is the highest one
    function automatic logic [SELW-1:0] f_decode(input logic [ADDRBITS-1:0] addr);
        logic [SELW-1:0] sel;
        sel = '0;
        for (int i = 0; i < NREGIONS; i++) begin
            if (addr >= BASES[i*ADDRBITS +: ADDRBITS]) begin
                sel = SELW'(i);
            end
        end
        return sel;
    endfunction

    assign w_rd_sel  = f_decode(bus.dread_addr);
    assign w_wr_sel  = f_decode(bus.dwrite_addr);
    assign w_rd_wait = WAITS[w_rd_sel*4 +: 4];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rsel  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rsel  <= w_rsel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rsel_nxt  = r_rsel;
        w_valid_nxt = 1'b0;
        w_rd_en     = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.dread_req) begin
                    w_rd_en[w_rd_sel] = 1'b1;
                    w_rsel_nxt        = w_rd_sel;
                    w_cnt_nxt         = w_rd_wait;
                    if (w_rd_wait == 4'd0) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < NREGIONS; i++) begin
            if (w_wr_sel == SELW'(i)) begin
`ifdef BUSDEC_WPROT_EN
                w_wr_en[2*i +: 2] = WPROT[i] ? 2'b00 : bus.dwrite_en;
`else
                w_wr_en[2*i +: 2] = bus.dwrite_en;
`endif
            end
        end
    end

    // Region strobes are held off for as long as reset is low
    assign bus.r_dread_en  = reset ? w_rd_en : '0;
    assign bus.r_dwrite_en = reset ? w_wr_en : '0;
    assign bus.stall       = (r_state == S_WAIT);
    assign bus.dread_valid = r_valid;
    assign bus.dread_data  = r_valid ? bus.r_dread_data[r_rsel*DATABITS +: DATABITS] : '0;

`ifdef BUSDEC_WPROT_EN
    logic r_wp_fault;
    logic w_wp_hit;

    assign w_wp_hit = (bus.dwrite_en != 2'b00) && WPROT[w_wr_sel];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp_fault <= 1'b0;
        end else if (w_wp_hit) begin
            r_wp_fault <= 1'b1;
        end
    end

    assign bus.wp_fault = r_wp_fault;
`else
    assign bus.wp_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_bus_decoder
// Description : Self-checking bench for bus_decoder (vector tables, corner
//               sequences, random traffic against a cycle-count model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_decoder;

`ifdef BUSDEC_WPROT_EN
    localparam bit C_WP_ON = 1'b1;
`else
    localparam bit C_WP_ON = 1'b0;
`endif
    localparam logic [3:0] C_WPROT = 4'b1000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    bus_decoder_if #(.NREGIONS(4), .ADDRBITS(16), .DATABITS(16)) bus ();

    bus_decoder #(
        .NREGIONS (4),
        .ADDRBITS (16),
        .DATABITS (16),
        .BASES    ({16'hC000, 16'h4000, 16'h2000, 16'h0000}),
        .WAITS    ({4'd2, 4'd1, 4'd0, 4'd0}),
        .WPROT    (C_WPROT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  wen;
        logic [7:0]  exp_wen;
    } wvec_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  exp_en;
        int          waits;
        logic [15:0] exp_data;
    } rvec_t;

    int          bases_m[4] = '{0, 'h2000, 'h4000, 'hC000};
    int          waits_m[4] = '{0, 0, 1, 2};
    logic [15:0] edges_m[8] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h3FFF,
                                16'h4000, 16'hBFFF, 16'hC000, 16'hFFFF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int region_of(input logic [15:0] a);
        int r = 0;
        for (int i = 0; i < 4; i++) if (int'(a) >= bases_m[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] wen_model(input logic [15:0] a, input logic [1:0] w);
        logic [7:0] e = '0;
        int r = region_of(a);
        if (!(C_WP_ON && C_WPROT[r])) e[2*r +: 2] = w;
        return e;
    endfunction

    initial begin
        wvec_t wvec[6];
        rvec_t rvec[8];
        int    nvalid;
        int    pend, preg, done_at, wp_exp, r, rr, acc;
        logic [63:0] rdata;

        n_checks = 0;
        n_errors = 0;

        wvec[0] = '{16'h3FFF, 2'b10, 8'h08};
        wvec[1] = '{16'h4000, 2'b10, 8'h20};
        wvec[2] = '{16'h0000, 2'b11, 8'h03};
        wvec[3] = '{16'h1FFF, 2'b01, 8'h01};
        wvec[4] = '{16'h2000, 2'b11, 8'h0C};
        wvec[5] = '{16'hBFFF, 2'b01, 8'h10};

        rvec[0] = '{16'h1FFF, 4'b0001, 0, 16'hA5A5};
        rvec[1] = '{16'h0000, 4'b0001, 0, 16'hA5A5};
        rvec[2] = '{16'h2000, 4'b0010, 0, 16'hBEEF};
        rvec[3] = '{16'h3FFF, 4'b0010, 0, 16'hBEEF};
        rvec[4] = '{16'h4000, 4'b0100, 1, 16'h5A5A};
        rvec[5] = '{16'hBFFF, 4'b0100, 1, 16'h5A5A};
        rvec[6] = '{16'hC000, 4'b1000, 2, 16'h1234};
        rvec[7] = '{16'hFFFF, 4'b1000, 2, 16'h1234};

        // Reset with live requests: region strobes must stay low
        reset            = 1'b0;
        bus.dread_req    = 1'b1;
        bus.dread_addr   = 16'hC000;
        bus.dwrite_addr  = 16'h2000;
        bus.dwrite_en    = 2'b11;
        bus.r_dread_data = {16'h1234, 16'h5A5A, 16'hBEEF, 16'hA5A5};
        step();
        step();
        @(negedge clk);
        chk("rst_rd_en",  64'(bus.r_dread_en), 64'h0);
        chk("rst_wr_en",  64'(bus.r_dwrite_en), 64'h0);
        chk("rst_stall",  64'(bus.stall), 64'h0);
        chk("rst_valid",  64'(bus.dread_valid), 64'h0);
        chk("rst_data",   64'(bus.dread_data), 64'h0);
        chk("rst_wp",     64'(bus.wp_fault), 64'h0);
        step();
        reset         = 1'b1;
        bus.dread_req = 1'b0;
        bus.dwrite_en = 2'b00;

        foreach (wvec[i]) begin
            bus.dwrite_addr = wvec[i].addr;
            bus.dwrite_en   = wvec[i].wen;
            @(negedge clk);
            chk($sformatf("wr_tab%0d", i), 64'(bus.r_dwrite_en), 64'(wvec[i].exp_wen));
            step();
        end
        bus.dwrite_en = 2'b00;

        foreach (rvec[i]) begin
            bus.dread_req  = 1'b1;
            bus.dread_addr = rvec[i].addr;
            @(negedge clk);
            chk($sformatf("rd_tab%0d_en", i), 64'(bus.r_dread_en), 64'(rvec[i].exp_en));
            chk($sformatf("rd_tab%0d_idle", i), 64'({bus.stall, bus.dread_valid}), 64'h0);
            step();
            bus.dread_req = 1'b0;
            for (int k = 0; k < rvec[i].waits; k++) begin
                @(negedge clk);
                chk($sformatf("rd_tab%0d_stall", i), 64'({bus.stall, bus.dread_valid}), 64'h2);
                step();
            end
            @(negedge clk);
            chk($sformatf("rd_tab%0d_valid", i), 64'({bus.stall, bus.dread_valid}), 64'h1);
            chk($sformatf("rd_tab%0d_data", i), 64'(bus.dread_data), 64'(rvec[i].exp_data));
            step();
        end

        // Write forwarded in the middle of a region-3 stall
        bus.dread_req  = 1'b1;
        bus.dread_addr = 16'hC000;
        step();
        bus.dread_req   = 1'b0;
        bus.dwrite_addr = 16'h2000;
        bus.dwrite_en   = 2'b11;
        @(negedge clk);
        chk("stall_wr_en", 64'(bus.r_dwrite_en), 64'h0C);
        chk("stall_wr_stall", 64'(bus.stall), 64'h1);
        step();
        bus.dwrite_en = 2'b00;
        @(negedge clk);
        chk("stall_wr_n2", 64'({bus.stall, bus.dread_valid}), 64'h2);
        step();
        @(negedge clk);
        chk("stall_wr_n3", 64'({bus.stall, bus.dread_valid, bus.dread_data}), {46'h0, 2'b01, 16'h1234});
        step();

        // Back-to-back: new request accepted in the data-valid cycle
        bus.dread_req  = 1'b1;
        bus.dread_addr = 16'h1FFF;
        step();
        bus.dread_addr = 16'h4000;
        @(negedge clk);
        chk("b2b_valid", 64'({bus.dread_valid, bus.dread_data}), {47'h0, 1'b1, 16'hA5A5});
        chk("b2b_en", 64'(bus.r_dread_en), 64'h4);
        step();
        bus.dread_req = 1'b0;
        @(negedge clk);
        chk("b2b_stall", 64'({bus.stall, bus.dread_valid}), 64'h2);
        step();
        @(negedge clk);
        chk("b2b_data", 64'({bus.dread_valid, bus.dread_data}), {47'h0, 1'b1, 16'h5A5A});
        step();

        // Reset while waiting in region 3
        bus.dread_req  = 1'b1;
        bus.dread_addr = 16'hC000;
        step();
        bus.dread_req = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        chk("rstw_pre_stall", 64'(bus.stall), 64'h1);
        step();
        @(negedge clk);
        chk("rstw_after", 64'({bus.stall, bus.dread_valid, bus.dread_data}), 64'h0);
        step();
        reset  = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.dread_valid || bus.stall) nvalid++;
            step();
        end
        chk("rstw_no_valid", 64'(nvalid), 64'h0);

        // Write into the protectable region
        bus.dwrite_addr = 16'hC010;
        bus.dwrite_en   = 2'b01;
        @(negedge clk);
        chk("wp_wr_en", 64'(bus.r_dwrite_en), C_WP_ON ? 64'h0 : 64'h40);
        chk("wp_not_yet", 64'(bus.wp_fault), 64'h0);
        step();
        bus.dwrite_en = 2'b00;
        @(negedge clk);
        chk("wp_set", 64'(bus.wp_fault), 64'(C_WP_ON));
        step();
        step();
        @(negedge clk);
        chk("wp_held", 64'(bus.wp_fault), 64'(C_WP_ON));
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Random traffic against a cycle-count model
        pend    = 0;
        preg    = 0;
        done_at = 0;
        wp_exp  = 0;
        for (int c = 0; c < 600; c++) begin
            bus.dread_req   = 1'($urandom_range(0, 1));
            bus.dread_addr  = ($urandom_range(0, 2) == 0) ? edges_m[$urandom_range(0, 7)] : 16'($urandom);
            bus.dwrite_addr = ($urandom_range(0, 2) == 0) ? edges_m[$urandom_range(0, 7)] : 16'($urandom);
            bus.dwrite_en   = 2'($urandom_range(0, 3));
            rdata           = {32'($urandom), 32'($urandom)};
            bus.r_dread_data = rdata;
            @(negedge clk);
            r   = region_of(bus.dread_addr);
            acc = (bus.dread_req && !(pend != 0 && c < done_at)) ? 1 : 0;
            chk("rnd_stall", 64'(bus.stall), 64'(pend != 0 && c < done_at));
            chk("rnd_valid", 64'(bus.dread_valid), 64'(pend != 0 && c == done_at));
            chk("rnd_data", 64'(bus.dread_data),
                (pend != 0 && c == done_at) ? 64'(rdata[16*preg +: 16]) : 64'h0);
            chk("rnd_rd_en", 64'(bus.r_dread_en), acc != 0 ? 64'(1 << r) : 64'h0);
            chk("rnd_wr_en", 64'(bus.r_dwrite_en), 64'(wen_model(bus.dwrite_addr, bus.dwrite_en)));
            chk("rnd_wp", 64'(bus.wp_fault), 64'(wp_exp));
            rr = region_of(bus.dwrite_addr);
            if (C_WP_ON && C_WPROT[rr] && bus.dwrite_en != 2'b00) wp_exp = 1;
            if (pend != 0 && c == done_at) pend = 0;
            if (acc != 0) begin
                pend    = 1;
                preg    = r;
                done_at = c + 1 + waits_m[r];
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
